// File: rtl/writeback_regfile_pkg.sv
// writeback_regfile_pkg
// Shared definitions for the writeback / register-file block:
//   - default datapath width, register count and register address width
//   - wb_sel source encodings
//   - FSM state constants for the post-reset clearing sweep
package writeback_regfile_pkg;

  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;
  localparam int AW_DEF   = 5;

  // Writeback source select encodings.
  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_LOAD = 2'b01,
    WB_LINK = 2'b10,
    WB_RSVD = 2'b11
  } wb_sel_t;

  // Sweep FSM: INIT clears the array, RUN is terminal until reset.
  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

endpackage

// File: rtl/writeback_regfile_regfile_array.sv
// regfile_array
// NREG x XLEN register storage with one synchronous write port and two
// asynchronous read ports. The storage has no reset; the parent clears it
// with a sweep after reset and handles x0 forcing and write bypass.
// Ports:
//   clk     in   write clock
//   we      in   write enable
//   waddr   in   write address
//   wdata   in   write data
//   raddr1  in   read port 1 address
//   raddr2  in   read port 2 address
//   rdata1  out  read port 1 data (combinational)
//   rdata2  out  read port 2 data (combinational)
module regfile_array #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = 5
) (
  input  logic            clk,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [AW-1:0]   raddr1,
  input  logic [AW-1:0]   raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2
);

  logic [XLEN-1:0] mem [NREG];

  // Single write port; deliberately no reset so this maps onto plain storage.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata1 = mem[raddr1];
  assign rdata2 = mem[raddr2];

endmodule

// File: rtl/writeback_regfile.sv
// writeback_regfile
// Writeback stage: selects the commit value (ALU result, load data or link
// address), writes it into the integer register file, and serves the two
// decode read ports with same-cycle write-through bypass. After reset it
// sweeps zeros through the array (the storage itself has no reset) and only
// then raises ready. Also counts retired instructions and flags reserved
// wb_sel encodings with a sticky error.
// Ports:
//   clk           in   system clock
//   rst_n         in   asynchronous active-low reset
//   wb_valid      in   valid instruction from data-memory stage
//   wb_sel        in   writeback source select
//   w_reg         in   instruction writes a destination register
//   dst_addr      in   destination register index
//   alu_result    in   ALU / branch-target result
//   rd_data       in   extended load data
//   next_pc       in   link value (pc+4)
//   rs1_addr      in   read port 1 address
//   rs2_addr      in   read port 2 address
//   rs1_data      out  read port 1 data (combinational)
//   rs2_data      out  read port 2 data (combinational)
//   ready         out  stage accepts writes and read data is valid
//   retire_count  out  retired-instruction counter (wraps)
//   wb_err        out  sticky reserved-wb_sel flag
module writeback_regfile
  import writeback_regfile_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREG = NREG_DEF,
  parameter int AW   = AW_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wb_valid,
  input  logic [1:0]      wb_sel,
  input  logic            w_reg,
  input  logic [AW-1:0]   dst_addr,
  input  logic [XLEN-1:0] alu_result,
  input  logic [XLEN-1:0] rd_data,
  input  logic [XLEN-1:0] next_pc,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            ready,
  output logic [31:0]     retire_count,
  output logic            wb_err
);

  localparam logic [AW-1:0] LAST_IDX = AW'(NREG - 1);
  localparam logic [AW-1:0] ZERO_IDX = {AW{1'b0}};

  logic [0:0]      state;
  logic [AW-1:0]   sweep_idx;
  logic            in_run;
  logic            is_rsvd;
  logic            we;
  logic [XLEN-1:0] commit;

  logic            arr_we;
  logic [AW-1:0]   arr_waddr;
  logic [XLEN-1:0] arr_wdata;
  logic [XLEN-1:0] arr_rdata1;
  logic [XLEN-1:0] arr_rdata2;

  assign in_run  = (state == ST_RUN);
  assign is_rsvd = (wb_sel == WB_RSVD);
  assign we      = in_run & wb_valid & w_reg & (dst_addr != ZERO_IDX) & ~is_rsvd;

  // Commit value mux; the reserved encoding commits nothing.
  always_comb begin
    commit = {XLEN{1'b0}};
    case (wb_sel)
      WB_ALU:  commit = alu_result;
      WB_LOAD: commit = rd_data;
      WB_LINK: commit = next_pc;
      default: commit = {XLEN{1'b0}};
    endcase
  end

  // Array write port: the sweep owns it in INIT, the pipeline owns it in RUN.
  always_comb begin
    arr_we    = 1'b0;
    arr_waddr = ZERO_IDX;
    arr_wdata = {XLEN{1'b0}};
    if (in_run) begin
      arr_we    = we;
      arr_waddr = dst_addr;
      arr_wdata = commit;
    end else begin
      arr_we    = 1'b1;
      arr_waddr = sweep_idx;
      arr_wdata = {XLEN{1'b0}};
    end
  end

  regfile_array #(
    .XLEN (XLEN),
    .NREG (NREG),
    .AW   (AW)
  ) u_array (
    .clk    (clk),
    .we     (arr_we),
    .waddr  (arr_waddr),
    .wdata  (arr_wdata),
    .raddr1 (rs1_addr),
    .raddr2 (rs2_addr),
    .rdata1 (arr_rdata1),
    .rdata2 (arr_rdata2)
  );

  // Read port 1: zero during sweep and for x0, bypass a same-cycle write.
  always_comb begin
    rs1_data = {XLEN{1'b0}};
    if (!in_run) begin
      rs1_data = {XLEN{1'b0}};
    end else if (rs1_addr == ZERO_IDX) begin
      rs1_data = {XLEN{1'b0}};
    end else if (we && (rs1_addr == dst_addr)) begin
      rs1_data = commit;
    end else begin
      rs1_data = arr_rdata1;
    end
  end

  // Read port 2: same rules as port 1, evaluated independently.
  always_comb begin
    rs2_data = {XLEN{1'b0}};
    if (!in_run) begin
      rs2_data = {XLEN{1'b0}};
    end else if (rs2_addr == ZERO_IDX) begin
      rs2_data = {XLEN{1'b0}};
    end else if (we && (rs2_addr == dst_addr)) begin
      rs2_data = commit;
    end else begin
      rs2_data = arr_rdata2;
    end
  end

  // Sweep FSM: NREG clearing cycles, ready rises on the edge entering RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_INIT;
      sweep_idx <= ZERO_IDX;
      ready     <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          sweep_idx <= sweep_idx + AW'(1);
          if (sweep_idx == LAST_IDX) begin
            state <= ST_RUN;
            ready <= 1'b1;
          end
        end
        ST_RUN: begin
          state <= ST_RUN;
          ready <= 1'b1;
        end
        default: begin
          state     <= ST_INIT;
          sweep_idx <= ZERO_IDX;
          ready     <= 1'b0;
        end
      endcase
    end
  end

  // Retired-instruction counter: every valid instruction in RUN, wraps freely.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retire_count <= 32'd0;
    end else if (in_run && wb_valid) begin
      retire_count <= retire_count + 32'd1;
    end
  end

  // Sticky error on a reserved writeback select in RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_err <= 1'b0;
    end else if (in_run && wb_valid && is_rsvd) begin
      wb_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_writeback_regfile.sv
module tb_writeback_regfile;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wb_valid = 1'b0;
  logic [1:0]  wb_sel = 2'b00;
  logic        w_reg = 1'b0;
  logic [4:0]  dst_addr = 5'd0;
  logic [31:0] alu_result = 32'd0;
  logic [31:0] rd_data = 32'd0;
  logic [31:0] next_pc = 32'd0;
  logic [4:0]  rs1_addr = 5'd0;
  logic [4:0]  rs2_addr = 5'd0;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        ready;
  logic [31:0] retire_count;
  logic        wb_err;

  int checks = 0;
  int errors = 0;

  writeback_regfile dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wb_valid     (wb_valid),
    .wb_sel       (wb_sel),
    .w_reg        (w_reg),
    .dst_addr     (dst_addr),
    .alu_result   (alu_result),
    .rd_data      (rd_data),
    .next_pc      (next_pc),
    .rs1_addr     (rs1_addr),
    .rs2_addr     (rs2_addr),
    .rs1_data     (rs1_data),
    .rs2_data     (rs2_data),
    .ready        (ready),
    .retire_count (retire_count),
    .wb_err       (wb_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%08h expected=%08h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Architectural view: a register file that becomes usable 32 clock edges
  // after reset release, at which point every register reads zero.
  logic [31:0] m_regs [32];
  int          m_cycles = 0;
  logic [31:0] m_retire = 32'd0;
  logic        m_err = 1'b0;

  function automatic logic m_run();
    return (rst_n === 1'b1) && (m_cycles >= 32);
  endfunction

  function automatic logic [31:0] m_commit();
    case (wb_sel)
      2'd0:    return alu_result;
      2'd1:    return rd_data;
      2'd2:    return next_pc;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic m_writes();
    return m_run() && wb_valid && w_reg && (dst_addr != 5'd0) && (wb_sel != 2'd3);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (!m_run()) return 32'd0;
    if (a == 5'd0) return 32'd0;
    if (m_writes() && (a == dst_addr)) return m_commit();
    return m_regs[a];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cycles <= 0;
      m_retire <= 32'd0;
      m_err    <= 1'b0;
    end else if (m_cycles < 32) begin
      m_cycles <= m_cycles + 1;
      if (m_cycles == 31) begin
        for (int i = 0; i < 32; i++) m_regs[i] <= 32'd0;
      end
    end else begin
      if (wb_valid) m_retire <= m_retire + 32'd1;
      if (wb_valid && (wb_sel == 2'd3)) m_err <= 1'b1;
      if (m_writes()) m_regs[dst_addr] <= m_commit();
    end
  end

  // Every-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    check("cmp_ready",  {31'd0, ready},  {31'd0, m_run()});
    check("cmp_retire", retire_count,    m_retire);
    check("cmp_err",    {31'd0, wb_err}, {31'd0, m_err});
    check("cmp_rs1",    rs1_data,        m_read(rs1_addr));
    check("cmp_rs2",    rs2_data,        m_read(rs2_addr));
  end

  // ---------------- directed stimulus ----------------
  task automatic next_cycle();
    @(negedge clk);
    #1;
  endtask

  // Counts negedge samples with ready low after release; stops the INIT
  // stimulus as soon as ready is seen so nothing spills into RUN.
  task automatic wait_ready(input string name);
    int zeros;
    logic got;
    zeros = 0;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      #1;
      if (ready) begin
        got = 1'b1;
        wb_valid = 1'b0;
        wb_sel = 2'b00;
        w_reg = 1'b0;
      end else begin
        zeros++;
      end
    end
    check({name, "_ready_seen"}, {31'd0, got}, 32'd1);
    check({name, "_init_len"}, zeros, 32'd32);
  endtask

  initial begin
    // Valid traffic during the sweep, including a reserved select: all ignored.
    wb_valid = 1'b1; wb_sel = 2'b11; w_reg = 1'b1; dst_addr = 5'd7;
    alu_result = 32'h0BAD_0BAD;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    wait_ready("sweep1");
    #1;
    check("init_no_retire", retire_count, 32'd0);
    check("init_no_err", {31'd0, wb_err}, 32'd0);

    // Every register reads zero after the sweep.
    for (int a = 0; a < 32; a++) begin
      rs1_addr = 5'(a);
      rs2_addr = 5'(31 - a);
      #1;
      check("zero_rs1", rs1_data, 32'd0);
      check("zero_rs2", rs2_data, 32'd0);
      next_cycle();
    end

    // ALU write to x5 with same-cycle bypass on both ports.
    wb_valid = 1'b1; w_reg = 1'b1; wb_sel = 2'b00; dst_addr = 5'd5;
    alu_result = 32'hDEAD_BEEF; rs1_addr = 5'd5; rs2_addr = 5'd5;
    #1;
    check("x5_bypass_rs1", rs1_data, 32'hDEAD_BEEF);
    check("x5_bypass_rs2", rs2_data, 32'hDEAD_BEEF);
    next_cycle();
    wb_valid = 1'b0;
    #1;
    check("x5_array_rs1", rs1_data, 32'hDEAD_BEEF);
    check("x5_array_rs2", rs2_data, 32'hDEAD_BEEF);
    check("retire_1", retire_count, 32'd1);

    // Write to x0 is dropped.
    wb_valid = 1'b1; dst_addr = 5'd0; alu_result = 32'h1234_5678; rs1_addr = 5'd0;
    #1;
    check("x0_during", rs1_data, 32'd0);
    next_cycle();
    wb_valid = 1'b0;
    #1;
    check("x0_after", rs1_data, 32'd0);
    check("retire_2", retire_count, 32'd2);

    // Back-to-back link then load writes.
    wb_valid = 1'b1; wb_sel = 2'b10; next_pc = 32'h0000_0104; dst_addr = 5'd1;
    rs1_addr = 5'd1; rs2_addr = 5'd2;
    #1;
    check("x1_bypass", rs1_data, 32'h0000_0104);
    next_cycle();
    wb_sel = 2'b01; rd_data = 32'hFFFF_FF80; dst_addr = 5'd2;
    #1;
    check("x2_bypass", rs2_data, 32'hFFFF_FF80);
    check("x1_array", rs1_data, 32'h0000_0104);
    next_cycle();
    wb_valid = 1'b0;
    #1;
    check("x1_final", rs1_data, 32'h0000_0104);
    check("x2_final", rs2_data, 32'hFFFF_FF80);
    check("retire_4", retire_count, 32'd4);

    // Reserved select: no write, no bypass, sticky error, still retires.
    wb_valid = 1'b1; wb_sel = 2'b11; w_reg = 1'b1; dst_addr = 5'd3;
    alu_result = 32'hAAAA_5555; rd_data = 32'h5555_AAAA; next_pc = 32'h0000_0200;
    rs1_addr = 5'd3;
    #1;
    check("rsvd_no_bypass", rs1_data, 32'd0);
    check("rsvd_err_before", {31'd0, wb_err}, 32'd0);
    next_cycle();
    wb_sel = 2'b00; w_reg = 1'b0;
    #1;
    check("rsvd_err_set", {31'd0, wb_err}, 32'd1);
    check("rsvd_x3_unchanged", rs1_data, 32'd0);
    check("retire_5", retire_count, 32'd5);
    next_cycle();
    wb_valid = 1'b0;
    #1;
    check("rsvd_err_sticky", {31'd0, wb_err}, 32'd1);
    check("retire_6", retire_count, 32'd6);

    // Mid-cycle reset aborts RUN immediately; x5 is cleared by the new sweep.
    rs1_addr = 5'd5; rs2_addr = 5'd5;
    #1;
    check("x5_before_reset", rs1_data, 32'hDEAD_BEEF);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("rst_ready", {31'd0, ready}, 32'd0);
    check("rst_retire", retire_count, 32'd0);
    check("rst_err", {31'd0, wb_err}, 32'd0);
    wb_valid = 1'b1; wb_sel = 2'b00; w_reg = 1'b1; dst_addr = 5'd5;
    alu_result = 32'h1111_1111;
    @(posedge clk);
    #2 rst_n = 1'b1;
    wait_ready("sweep2");
    #1;
    check("x5_cleared_rs1", rs1_data, 32'd0);
    check("x5_cleared_rs2", rs2_data, 32'd0);
    check("sweep2_no_retire", retire_count, 32'd0);
    next_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
